// File: rtl/cp0_regfile.sv
// cp0_regfile -- MIPS coprocessor-0 register file.
//
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. Serves mfc0 reads
// combinationally and mtc0 writes on the clock edge. It also commits the
// architectural state changes for the exception code that the MEM-stage
// exception encoder resolves, including eret.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   we_i, waddr_i, data_i  mtc0 write enable / register number / data
//   raddr_i, data_o      mfc0 register number / read data (no write bypass)
//   int_i                external hardware interrupt lines (sampled into Cause IP)
//   except_type_i        encoded exception (0x1/4/5/8/9/a/c) or eret (0xe)
//   current_inst_addr_i  PC of the excepting instruction
//   is_in_delayslot_i    excepting instruction is in a branch delay slot
//   bad_addr_i           faulting virtual address for AdEL/AdES
//   count_o .. badvaddr_o  architectural register contents
//   timer_int_o          sticky timer interrupt (Count == Compare)
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    // IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Recognised exception codes; anything else is treated as "no exception".
    function automatic logic is_exception(input logic [31:0] et);
        case (et)
            32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc: is_exception = 1'b1;
            default:                                        is_exception = 1'b0;
        endcase
    endfunction

    // The encoder values were chosen so the ExcCode is the low bits, except
    // for interrupt (0x1) which maps to ExcCode 0.
    function automatic logic [4:0] exc_code(input logic [31:0] et);
        if (et == 32'h1)
            exc_code = 5'h00;
        else
            exc_code = et[4:0];
    endfunction

    logic        div_cnt;
    logic        div_cnt_n;
    logic [31:0] count_n, compare_n, status_n, cause_n, epc_n, badvaddr_n;
    logic        timer_int_n;

    logic exc_commit;
    logic eret_commit;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic count_tick;

    assign exc_commit  = is_exception(except_type_i);
    assign eret_commit = (except_type_i == 32'he);

    // Exception/eret commit takes priority over mtc0 to Status/Cause/EPC;
    // Count and Compare writes are never blocked.
    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == REG_STATUS) && !exc_commit && !eret_commit;
    assign wr_cause   = we_i && (waddr_i == REG_CAUSE)  && !exc_commit && !eret_commit;
    assign wr_epc     = we_i && (waddr_i == REG_EPC)    && !exc_commit && !eret_commit;

    // With COUNT_DIV==1 the divider stays at 0 and Count ticks every cycle.
    assign count_tick = (COUNT_DIV == 1) ? 1'b1 : div_cnt;

    always_comb begin
        div_cnt_n   = div_cnt;
        count_n     = count_o;
        compare_n   = compare_o;
        status_n    = status_o;
        cause_n     = cause_o;
        epc_n       = epc_o;
        badvaddr_n  = badvaddr_o;
        timer_int_n = timer_int_o;

        // Count and its divider
        if (wr_count) begin
            count_n   = data_i;
            div_cnt_n = 1'b0;
        end else begin
            if (count_tick)
                count_n = count_o + 32'd1;
            div_cnt_n = (COUNT_DIV == 1) ? 1'b0 : ~div_cnt;
        end

        // Compare and the sticky timer interrupt; the Compare write clears it.
        if (wr_compare) begin
            compare_n   = data_i;
            timer_int_n = 1'b0;
        end else if ((count_o == compare_o) && (compare_o != 32'd0)) begin
            timer_int_n = 1'b1;
        end

        // Hardware interrupt pending bits, timer folded into IP7.
        cause_n[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};

        if (wr_status)
            status_n = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        if (wr_cause)
            cause_n[9:8] = data_i[9:8];
        if (wr_epc)
            epc_n = data_i;

        if (exc_commit) begin
            // A nested exception (EXL already set) keeps the original EPC/BD.
            if (!status_o[1]) begin
                epc_n     = is_in_delayslot_i ? (current_inst_addr_i - 32'd4)
                                              : current_inst_addr_i;
                cause_n[31] = is_in_delayslot_i;
            end
            status_n[1]  = 1'b1;
            cause_n[6:2] = exc_code(except_type_i);
            if ((except_type_i == 32'h4) || (except_type_i == 32'h5))
                badvaddr_n = bad_addr_i;
        end else if (eret_commit) begin
            status_n[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= 1'b0;
            count_o     <= 32'd0;
            compare_o   <= 32'd0;
            status_o    <= STATUS_RESET;
            cause_o     <= 32'd0;
            epc_o       <= 32'd0;
            badvaddr_o  <= 32'd0;
            timer_int_o <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_n;
            count_o     <= count_n;
            compare_o   <= compare_n;
            status_o    <= status_n;
            cause_o     <= cause_n;
            epc_o       <= epc_n;
            badvaddr_o  <= badvaddr_n;
            timer_int_o <= timer_int_n;
        end
    end

    // mfc0 read mux: current contents only, no bypass of a same-cycle mtc0.
    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr_o;
            REG_COUNT:    data_o = count_o;
            REG_COMPARE:  data_o = compare_o;
            REG_STATUS:   data_o = status_o;
            REG_CAUSE:    data_o = cause_o;
            REG_EPC:      data_o = epc_o;
            REG_PRID:     data_o = PRID_VALUE;
            default:      data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
    logic        timer_int_o;

    int checks   = 0;
    int failures = 0;

    cp0_regfile #(.PRID_VALUE(32'h0000_4220), .COUNT_DIV(2)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .int_i(int_i), .except_type_i(except_type_i),
        .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
        .bad_addr_i(bad_addr_i), .data_o(data_o), .count_o(count_o),
        .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 0; waddr_i = 0; raddr_i = 0; data_i = 0; int_i = 0;
        except_type_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
        checks++; if (cause_o !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", cause_o); end
        checks++; if (epc_o !== 32'h0 || compare_o !== 32'h0 || badvaddr_o !== 32'h0) begin failures++; $display("FAIL reset_regs epc=%h cmp=%h bva=%h exp=0", epc_o, compare_o, badvaddr_o); end
        checks++; if (count_o !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", count_o); end
        repeat (10) tick();
        checks++; if (count_o !== 32'd5) begin failures++; $display("FAIL count_after_10 got=%0d exp=5", count_o); end
        checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL idle_timer got=%b exp=0", timer_int_o); end
        checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL idle_status got=%h exp=%h", status_o, 32'h0040_0000); end
    endtask

    task automatic test_timer();
        int n;
        do_reset();
        we_i = 1; waddr_i = 5'd11; data_i = 32'd6;
        tick();
        idle_inputs();
        n = 0;
        while (count_o !== 32'd6 && n < 40) begin
            checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL timer_early count=%0d got=%b exp=0", count_o, timer_int_o); end
            tick();
            n++;
        end
        checks++;
        if (count_o !== 32'd6) begin
            failures++; $display("FAIL timer_count_reach got=%0d exp=6", count_o);
        end else begin
            checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL timer_at_match got=%b exp=0", timer_int_o); end
            tick();
            checks++; if (timer_int_o !== 1'b1) begin failures++; $display("FAIL timer_set got=%b exp=1", timer_int_o); end
            tick();
            checks++; if (cause_o[15] !== 1'b1) begin failures++; $display("FAIL cause_ip7 got=%b exp=1", cause_o[15]); end
            checks++; if (timer_int_o !== 1'b1) begin failures++; $display("FAIL timer_sticky got=%b exp=1", timer_int_o); end
            we_i = 1; waddr_i = 5'd11; data_i = 32'h20; raddr_i = 5'd11;
            tick();
            we_i = 0;
            checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL timer_clear got=%b exp=0", timer_int_o); end
            checks++; if (data_o !== 32'h20) begin failures++; $display("FAIL read_compare got=%h exp=20", data_o); end
        end
    endtask

    task automatic test_exception();
        do_reset();
        except_type_i = 32'hc; current_inst_addr_i = 32'hBFC0_0100; is_in_delayslot_i = 1;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'hBFC0_00FC) begin failures++; $display("FAIL exc_epc_ds got=%h exp=%h", epc_o, 32'hBFC0_00FC); end
        checks++; if (cause_o[31] !== 1'b1) begin failures++; $display("FAIL exc_bd got=%b exp=1", cause_o[31]); end
        checks++; if (cause_o[6:2] !== 5'h0c) begin failures++; $display("FAIL exc_code_c got=%h exp=0c", cause_o[6:2]); end
        checks++; if (status_o !== 32'h0040_0002) begin failures++; $display("FAIL exc_exl_set got=%h exp=%h", status_o, 32'h0040_0002); end
        except_type_i = 32'h4; current_inst_addr_i = 32'h0000_2000; bad_addr_i = 32'h1234_5671;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'hBFC0_00FC) begin failures++; $display("FAIL nested_epc got=%h exp=%h", epc_o, 32'hBFC0_00FC); end
        checks++; if (cause_o[31] !== 1'b1) begin failures++; $display("FAIL nested_bd got=%b exp=1", cause_o[31]); end
        checks++; if (cause_o[6:2] !== 5'h04) begin failures++; $display("FAIL nested_code got=%h exp=04", cause_o[6:2]); end
        checks++; if (badvaddr_o !== 32'h1234_5671) begin failures++; $display("FAIL badvaddr got=%h exp=%h", badvaddr_o, 32'h1234_5671); end
        except_type_i = 32'he;
        tick();
        idle_inputs();
        checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL eret_status got=%h exp=%h", status_o, 32'h0040_0000); end
        checks++; if (cause_o[6:2] !== 5'h04 || epc_o !== 32'hBFC0_00FC) begin failures++; $display("FAIL eret_hold code=%h epc=%h exp=04/%h", cause_o[6:2], epc_o, 32'hBFC0_00FC); end
        except_type_i = 32'h2; current_inst_addr_i = 32'h0000_3000;
        tick();
        idle_inputs();
        checks++; if (status_o !== 32'h0040_0000 || epc_o !== 32'hBFC0_00FC) begin failures++; $display("FAIL bogus_code status=%h epc=%h exp=%h/%h", status_o, epc_o, 32'h0040_0000, 32'hBFC0_00FC); end
    endtask

    task automatic test_conflict();
        do_reset();
        we_i = 1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF;
        except_type_i = 32'h8; current_inst_addr_i = 32'h8000_0040;
        tick();
        idle_inputs();
        checks++; if (epc_o !== 32'h8000_0040) begin failures++; $display("FAIL conflict_epc got=%h exp=%h", epc_o, 32'h8000_0040); end
        checks++; if (cause_o[6:2] !== 5'h08 || cause_o[31] !== 1'b0) begin failures++; $display("FAIL conflict_cause got=%h exp code 08 bd 0", cause_o); end
        we_i = 1; waddr_i = 5'd9; data_i = 32'h100; except_type_i = 32'h1; current_inst_addr_i = 32'h0000_0500;
        tick();
        idle_inputs();
        checks++; if (count_o !== 32'h100) begin failures++; $display("FAIL conflict_count got=%h exp=100", count_o); end
        checks++; if (cause_o[6:2] !== 5'h00 || epc_o !== 32'h8000_0040) begin failures++; $display("FAIL int_code code=%h epc=%h exp=00/%h", cause_o[6:2], epc_o, 32'h8000_0040); end
        tick();
        checks++; if (count_o !== 32'h100) begin failures++; $display("FAIL count_div_clear got=%h exp=100", count_o); end
        tick();
        checks++; if (count_o !== 32'h101) begin failures++; $display("FAIL count_inc got=%h exp=101", count_o); end
    endtask

    task automatic test_mtc0();
        do_reset();
        we_i = 1; waddr_i = 5'd12; data_i = 32'hFFFF_FFFF;
        tick();
        checks++; if (status_o !== 32'h0040_FF03) begin failures++; $display("FAIL status_mask got=%h exp=%h", status_o, 32'h0040_FF03); end
        waddr_i = 5'd8; data_i = 32'h55;
        tick();
        checks++; if (badvaddr_o !== 32'h0) begin failures++; $display("FAIL badvaddr_ro got=%h exp=0", badvaddr_o); end
        waddr_i = 5'd13; data_i = 32'hFFFF_FFFF; int_i = 6'b000101;
        tick();
        we_i = 0; raddr_i = 5'd13;
        #1;
        checks++; if (cause_o !== 32'h0000_1700) begin failures++; $display("FAIL cause_write got=%h exp=%h", cause_o, 32'h0000_1700); end
        checks++; if (data_o !== 32'h0000_1700) begin failures++; $display("FAIL read_cause got=%h exp=%h", data_o, 32'h0000_1700); end
        raddr_i = 5'd15; #1;
        checks++; if (data_o !== 32'h0000_4220) begin failures++; $display("FAIL read_prid got=%h exp=%h", data_o, 32'h0000_4220); end
        raddr_i = 5'd7; #1;
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL read_unmapped got=%h exp=0", data_o); end
        raddr_i = 5'd12; #1;
        checks++; if (data_o !== 32'h0040_FF03) begin failures++; $display("FAIL read_status got=%h exp=%h", data_o, 32'h0040_FF03); end
        we_i = 1; waddr_i = 5'd14; data_i = 32'h0000_1234; raddr_i = 5'd14; #1;
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL read_no_bypass got=%h exp=0", data_o); end
        tick();
        checks++; if (data_o !== 32'h0000_1234) begin failures++; $display("FAIL read_epc got=%h exp=1234", data_o); end
        // eret drops a simultaneous Status write but still clears EXL
        waddr_i = 5'd12; data_i = 32'h0; except_type_i = 32'he;
        tick();
        idle_inputs();
        checks++; if (status_o !== 32'h0040_FF01) begin failures++; $display("FAIL eret_vs_mtc0 got=%h exp=%h", status_o, 32'h0040_FF01); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        we_i = 1; waddr_i = 5'd9; data_i = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        checks++; if (count_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_load got=%h exp=ffffffff", count_o); end
        tick();
        tick();
        checks++; if (count_o !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", count_o); end
        we_i = 1; waddr_i = 5'd9; data_i = 32'h77; except_type_i = 32'hc; rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        checks++; if (count_o !== 32'h0 || status_o !== 32'h0040_0000 || cause_o !== 32'h0) begin failures++; $display("FAIL reset_override count=%h status=%h cause=%h", count_o, status_o, cause_o); end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_timer();
        test_exception();
        test_conflict();
        test_mtc0();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
